fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded into the fetch PC on reset.
REQ-002 Parameter PC_STEP, 4, byte increment between sequential fetches.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en  input  1  1 = fetching permitted; 0 = fetching paused, buffer still drains.
REQ-006 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_pc  output  32  address to combinational instruction memory; equals the fetch PC register.
REQ-009 imem_instr  input  32  instruction word returned by memory in the same cycle for imem_pc.
REQ-010 out_valid  output  1  buffer head holds a valid fetched instruction.
REQ-011 out_ready  input  1  decode stage accepts the head this cycle.
REQ-012 out_pc  output  32  PC of the head entry.
REQ-013 out_instr  output  32  instruction of the head entry.

Function
REQ-014 Block SHALL contain a 32-bit fetch PC register, a 2-entry FIFO of {pc, instr}, a 2-bit occupancy count (0..2), and head/tail pointers.
REQ-015 imem_pc SHALL equal the fetch PC register at all times (no combinational path from any input).
REQ-016 pop SHALL be out_valid && out_ready; out_valid SHALL be (count != 0); out_pc/out_instr SHALL be the head entry fields, registered, with no input-to-output combinational path.
REQ-017 fetch SHALL be fetch_en && !redirect_valid && (count < 2 || pop).
REQ-018 On fetch: push {fetch PC, imem_instr} at tail; fetch PC <= fetch PC + PC_STEP, modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; this SHALL be allowed at count 1 and count 2.
REQ-020 Full (count 2, no pop): no fetch; fetch PC and FIFO contents SHALL hold; imem_pc stable.
REQ-021 Empty (count 0): out_valid 0; out_pc/out_instr are don't-care; out_ready ignored.
REQ-022 Latency: an instruction fetched in cycle N SHALL appear at the head by cycle N+1 when the FIFO was empty or held only the popped entry.
REQ-023 Redirect has top priority: in a redirect_valid cycle, a pop handshake, if present, SHALL complete; then at the edge the FIFO SHALL flush (count 0, pointers 0) and fetch PC <= {redirect_pc[31:2], 2'b00}; no push occurs that cycle.
REQ-024 The first fetch from the redirect target SHALL occur in the cycle after redirect_valid (if fetch_en=1); out_valid SHALL be 1 in the cycle after that.
REQ-025 Back-to-back redirects SHALL each take effect; the last one wins and no intermediate target is fetched.
REQ-026 fetch_en=0 with redirect_valid=1 SHALL still flush and load the fetch PC.
REQ-027 Pointer wrap: head/tail SHALL toggle 0->1->0; FIFO order SHALL be strictly preserved.

Reset
REQ-028 While rst_n=0 (asynchronously, regardless of clk): fetch PC = RESET_PC, count = 0, head = tail = 0, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries immediately; no partial pop or push SHALL be visible after release.
REQ-030 The first fetch after release SHALL occur on the first rising edge with rst_n=1 and fetch_en=1, at address RESET_PC.

Verification
REQ-031 Reset release, fetch_en=1, out_ready=1, memory NOPs -> out_pc sequence 0x0, 0x4, 0x8, ..., one per cycle starting the cycle after the first fetch; out_instr 32'h00000013.
REQ-032 out_ready=0 for 5 cycles -> count saturates at 2, imem_pc holds at 0x8, out_pc stays 0x0; then out_ready=1 -> 0x0, 0x4, 0x8 in order with no loss or duplicate.
REQ-033 Redirect to 0x40 while count=2 with a concurrent pop -> popped entry delivered, FIFO flushed, imem_pc=0x40 next cycle, next out_pc=0x40.
REQ-034 redirect_pc=0x43 -> fetch PC 0x40; fetch PC 0xFFFF_FFFC -> next fetch PC 0x0000_0000.
REQ-035 rst_n pulsed low asynchronously (between edges) with count=2 -> out_valid=0 and imem_pc=RESET_PC immediately; sequence restarts at RESET_PC.
REQ-036 fetch_en=0 with count=2, out_ready=1 -> two entries drain, out_valid=0, imem_pc unchanged until fetch_en returns to 1.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end: a sequential fetch PC feeding a two-entry
// {pc, instr} skid buffer toward decode, with a redirect path that flushes
// the buffer and reloads the PC.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0] pc_q;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;
  logic        head;
  logic        tail;

  logic        pop;
  logic        fetch;
  logic [1:0]  count_nxt;

  // Handshake and fetch decisions; redirect suppresses any push this cycle.
  always_comb begin
    pop       = (count != 2'd0) && out_ready;
    fetch     = fetch_en && !redirect_valid && ((count < 2'd2) || pop);
    count_nxt = count;
    case ({fetch, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Fetch PC, buffer storage and pointers; redirect flushes and reloads the
  // PC word-aligned, after the concurrent pop (if any) has been presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      pc_q  <= {redirect_pc[31:2], 2'b00};
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (pop) begin
        head <= ~head;
      end
      if (fetch) begin
        buf_pc[tail]    <= pc_q;
        buf_instr[tail] <= imem_instr;
        tail            <= ~tail;
        pc_q            <= pc_q + PC_STEP;
      end
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  always_comb begin
    imem_pc   = pc_q;
    out_valid = (count != 2'd0);
    out_pc    = buf_pc[head];
    out_instr = buf_instr[head];
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: one task per scenario, inline checks.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        nop_mode = 1'b0;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  // Combinational memory model: NOPs, or a word tagged by its own address.
  assign imem_instr = nop_mode ? 32'h0000_0013 : (imem_pc ^ KEY);

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT freshly reset, 3 time units after a rising edge, idle inputs.
  task automatic do_reset();
    @(posedge clk);
    #1;
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL rst_imem_pc got=%h want=%h", imem_pc, 32'h0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h want=0", out_instr); end
  endtask

  task automatic test_stream();
    do_reset();
    nop_mode = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", k, out_valid); end
      total++; if (out_pc !== 32'(4*k)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", k, out_pc, 32'(4*k)); end
      total++; if (out_instr !== 32'h13) begin bad++; $display("FAIL stream_instr[%0d] got=%h want=13", k, out_instr); end
      total++; if (imem_pc !== 32'(4*k+4)) begin bad++; $display("FAIL stream_imem[%0d] got=%h want=%h", k, imem_pc, 32'(4*k+4)); end
    end
    nop_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = (k == 1) ? 32'h4 : 32'h8;
      total++; if (imem_pc !== exp) begin bad++; $display("FAIL bp_imem[%0d] got=%h want=%h", k, imem_pc, exp); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL bp_out_pc[%0d] got=%h want=0", k, out_pc); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = 32'(4*k);
      total++; if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== (exp ^ KEY)) begin
        bad++; $display("FAIL bp_drain[%0d] got=%b/%h/%h want=1/%h/%h", k, out_valid, out_pc, out_instr, exp, exp ^ KEY); end
      total++; if (imem_pc !== exp + 32'h8) begin bad++; $display("FAIL bp_full_pushpop[%0d] got=%h want=%h", k, imem_pc, exp + 32'h8); end
      step();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    step(); step();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL rd_pop_head got=%b/%h want=1/0", out_valid, out_pc); end
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_flush got=%b want=0", out_valid); end
    total++; if (imem_pc !== 32'h40) begin bad++; $display("FAIL rd_imem got=%h want=40", imem_pc); end
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin bad++; $display("FAIL rd_first got=%b/%h want=1/40", out_valid, out_pc); end
    total++; if (out_instr !== (32'h40 ^ KEY)) begin bad++; $display("FAIL rd_first_instr got=%h want=%h", out_instr, 32'h40 ^ KEY); end
    total++; if (imem_pc !== 32'h44) begin bad++; $display("FAIL rd_next_imem got=%h want=44", imem_pc); end
  endtask

  task automatic test_align_wrap();
    do_reset();
    fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    total++; if (imem_pc !== 32'h40) begin bad++; $display("FAIL align got=%h want=40", imem_pc); end
    redirect_pc = 32'hFFFF_FFFE; fetch_en = 1'b1; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h want=fffffffc", imem_pc); end
    step();
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", imem_pc); end
    total++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== (32'hFFFF_FFFC ^ KEY)) begin
      bad++; $display("FAIL wrap_head got=%h/%h want=fffffffc/%h", out_pc, out_instr, 32'hFFFF_FFFC ^ KEY); end
    step();
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL wrap_after got=%h want=0", out_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || imem_pc !== 32'h200) begin bad++; $display("FAIL b2b_flush got=%b/%h want=0/200", out_valid, imem_pc); end
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin bad++; $display("FAIL b2b_head got=%b/%h want=1/200", out_valid, out_pc); end
    total++; if (imem_pc !== 32'h204) begin bad++; $display("FAIL b2b_imem got=%h want=204", imem_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    total++; if (out_pc !== 32'h80 || imem_pc !== 32'h88) begin bad++; $display("FAIL ar_fill got=%h/%h want=80/88", out_pc, imem_pc); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || imem_pc !== 32'h0) begin bad++; $display("FAIL ar_now got=%b/%h want=0/0", out_valid, imem_pc); end
    total++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin bad++; $display("FAIL ar_out got=%h/%h want=0/0", out_pc, out_instr); end
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_pc !== 32'h4) begin
      bad++; $display("FAIL ar_restart got=%b/%h/%h want=1/0/4", out_valid, out_pc, imem_pc); end
    step();
    total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL ar_second got=%h want=4", out_pc); end
  endtask

  task automatic test_drain();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    step(); step();
    fetch_en = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL dr_head0 got=%b/%h want=1/0", out_valid, out_pc); end
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_pc !== 32'h8) begin
      bad++; $display("FAIL dr_head1 got=%b/%h/%h want=1/4/8", out_valid, out_pc, imem_pc); end
    step();
    total++; if (out_valid !== 1'b0 || imem_pc !== 32'h8) begin bad++; $display("FAIL dr_empty got=%b/%h want=0/8", out_valid, imem_pc); end
    step();
    total++; if (out_valid !== 1'b0 || imem_pc !== 32'h8) begin bad++; $display("FAIL dr_hold got=%b/%h want=0/8", out_valid, imem_pc); end
    fetch_en = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || imem_pc !== 32'hC) begin
      bad++; $display("FAIL dr_resume got=%b/%h/%h want=1/8/c", out_valid, out_pc, imem_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_align_wrap();
    test_back_to_back();
    test_async_reset();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
